// File: rtl/sdram_arbiter_pkg.sv
// Shared types and sizing helpers for the SDRAM port arbiter.
// Widths depend on each instance's parameters, so they are computed by the functions below.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } arb_state_t;

  // Grant index width; a single-bit index is kept even for one client.
  function automatic int idx_width(input int n_clients);
    return (n_clients > 1) ? $clog2(n_clients) : 1;
  endfunction

  // Bits needed for a down-counter that is loaded with max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count + 1) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Client request/response bus and sdram_ctrl burst port of the arbiter.
// The arbiter uses the slave view; client logic and the controller model use the master view.
interface sdram_arbiter_if #(
  parameter int NumClients  = 2,
  parameter int AddrWidth   = 22,
  parameter int DataWidth   = 16,
  parameter int BurstLength = 4
);

  localparam int BurstW = BurstLength * DataWidth;

  logic [NumClients-1:0]                 i_req;
  logic [NumClients-1:0]                 i_we;
  logic [NumClients-1:0][AddrWidth-1:0]  i_addr;
  logic [NumClients-1:0][BurstW-1:0]     i_wdata;
  logic [NumClients-1:0]                 o_ack;
  logic [NumClients-1:0]                 o_rvalid;
  logic [BurstW-1:0]                     o_rdata;
  logic                                  o_err;
  logic                                  o_busy;

  logic                                  o_wr_req;
  logic                                  o_rd_req;
  logic [AddrWidth-1:0]                  o_wr_addr;
  logic [AddrWidth-1:0]                  o_rd_addr;
  logic [BurstW-1:0]                     o_wr_data;
  logic [BurstW-1:0]                     i_rd_data;
  logic                                  i_rd_rdy;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_rd_data, i_rd_rdy,
    output o_ack, o_rvalid, o_rdata, o_err, o_busy,
    output o_wr_req, o_rd_req, o_wr_addr, o_rd_addr, o_wr_data
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_rd_data, i_rd_rdy,
    input  o_ack, o_rvalid, o_rdata, o_err, o_busy,
    input  o_wr_req, o_rd_req, o_wr_addr, o_rd_addr, o_wr_data
  );

endinterface

// File: rtl/sdram_arbiter_rr_arbiter.sv
// Round-robin request picker: searches from last_grant+1 upward, wrapping modulo NumClients.
// The pointer moves only when the caller enables it and someone is actually requesting.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NumClients = 2,
  localparam int IdxW = idx_width(NumClients)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NumClients-1:0] i_req,
  input  logic                  i_en,
  output logic [NumClients-1:0] o_grant,
  output logic [IdxW-1:0]       o_grant_idx
);

  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    found       = 1'b0;
    cand        = '0;
    o_grant_idx = '0;
    for (int k = 1; k <= NumClients; k++) begin
      cand = IdxW'((int'(last_grant_q) + k) % NumClients);
      if (!found && i_req[cand]) begin
        found       = 1'b1;
        o_grant_idx = cand;
      end
    end
    o_grant      = found ? (NumClients'(1) << o_grant_idx) : '0;
    last_grant_d = (i_en && found) ? o_grant_idx : last_grant_q;
  end

  // Reset points at the last client so client 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= IdxW'(NumClients - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one sdram_ctrl burst port among NumClients requesters, one operation at a time.
// Grant is held until the read returns (or times out) or the write recovery count expires.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NumClients  = 2,
  parameter int AddrWidth   = 22,
  parameter int DataWidth   = 16,
  parameter int BurstLength = 4,
  parameter int WrRecovery  = 16,
  parameter int RdTimeout   = 255
) (
  input logic            i_sys_clk,
  input logic            i_rst_n,
  sdram_arbiter_if.slave bus
);

  localparam int IdxW   = idx_width(NumClients);
  localparam int WrCntW = cnt_width(WrRecovery - 1);
  localparam int ToCntW = cnt_width(RdTimeout - 1);
  localparam int BurstW = BurstLength * DataWidth;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ISSUE   = ISSUE;
  localparam logic [1:0] ST_WAIT_RD = WAIT_RD;
  localparam logic [1:0] ST_WAIT_WR = WAIT_WR;

  logic [1:0]            state_q, state_d;
  logic [IdxW-1:0]       gidx_q, gidx_d;
  logic                  we_q, we_d;
  logic [WrCntW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [ToCntW-1:0]     to_cnt_q, to_cnt_d;
  logic [NumClients-1:0] ack_q, ack_d;
  logic [NumClients-1:0] rvalid_q, rvalid_d;
  logic [BurstW-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  wr_req_q, wr_req_d;
  logic                  rd_req_q, rd_req_d;
  logic [AddrWidth-1:0]  wr_addr_q, wr_addr_d;
  logic [AddrWidth-1:0]  rd_addr_q, rd_addr_d;
  logic [BurstW-1:0]     wr_data_q, wr_data_d;

  logic                  arb_en;
  logic [NumClients-1:0] grant;
  logic [IdxW-1:0]       grant_idx;

  rr_arbiter #(
    .NumClients (NumClients)
  ) u_rr_arbiter (
    .clk         (i_sys_clk),
    .rst_n       (i_rst_n),
    .i_req       (bus.i_req),
    .i_en        (arb_en),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  // Strobes and pulses are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    we_d      = we_q;
    wr_cnt_d  = wr_cnt_q;
    to_cnt_d  = to_cnt_q;
    ack_d     = '0;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    wr_req_d  = 1'b0;
    rd_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    arb_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (|bus.i_req) begin
          gidx_d = grant_idx;
          we_d   = bus.i_we[grant_idx];
          ack_d  = grant;
          if (bus.i_we[grant_idx]) begin
            wr_req_d  = 1'b1;
            wr_addr_d = bus.i_addr[grant_idx];
            wr_data_d = bus.i_wdata[grant_idx];
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = bus.i_addr[grant_idx];
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          wr_cnt_d = WrCntW'(WrRecovery - 1);
          state_d  = ST_WAIT_WR;
        end else begin
          to_cnt_d = ToCntW'(RdTimeout - 1);
          state_d  = ST_WAIT_RD;
        end
      end

      ST_WAIT_WR: begin
        if (wr_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q - 1'b1;
        end
      end

      // A ready arriving on the last allowed cycle still completes the read.
      ST_WAIT_RD: begin
        if (bus.i_rd_rdy) begin
          rdata_d  = bus.i_rd_data;
          rvalid_d = NumClients'(1) << gidx_q;
          state_d  = ST_IDLE;
        end else if (to_cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      gidx_q    <= '0;
      we_q      <= 1'b0;
      wr_cnt_q  <= '0;
      to_cnt_q  <= '0;
      ack_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      we_q      <= we_d;
      wr_cnt_q  <= wr_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.o_ack     = ack_q;
  assign bus.o_rvalid  = rvalid_q;
  assign bus.o_rdata   = rdata_q;
  assign bus.o_err     = err_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_wr_req  = wr_req_q;
  assign bus.o_rd_req  = rd_req_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_rd_addr = rd_addr_q;
  assign bus.o_wr_data = wr_data_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a scoreboard queue of expected output events
// is filled as requests are driven and drained by a monitor on the falling edge.
module tb_sdram_arbiter;

  localparam int NUM_CLIENTS = 2;
  localparam int ADDR_W      = 22;
  localparam int DATA_W      = 16;
  localparam int BURST_LEN   = 4;
  localparam int WR_REC      = 6;
  localparam int RD_TO       = 10;
  localparam int BURST_W     = BURST_LEN * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(
    .NumClients  (NUM_CLIENTS),
    .AddrWidth   (ADDR_W),
    .DataWidth   (DATA_W),
    .BurstLength (BURST_LEN)
  ) bus ();

  sdram_arbiter #(
    .NumClients  (NUM_CLIENTS),
    .AddrWidth   (ADDR_W),
    .DataWidth   (DATA_W),
    .BurstLength (BURST_LEN),
    .WrRecovery  (WR_REC),
    .RdTimeout   (RD_TO)
  ) dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic                   is_ack;
    logic [NUM_CLIENTS-1:0] ack;
    logic                   wr;
    logic [ADDR_W-1:0]      addr;
    logic [BURST_W-1:0]     data;
    logic [NUM_CLIENTS-1:0] rvalid;
    logic                   err;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_checks = 0;
  int  n_fail = 0;

  int lat, busy_n, err_lat, acks0, acks1;
  logic [BURST_W-1:0] rd_exp;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [255:0] allOutputs();
    return 256'({bus.o_ack, bus.o_rvalid, bus.o_rdata, bus.o_err, bus.o_busy,
                 bus.o_wr_req, bus.o_rd_req, bus.o_wr_addr, bus.o_rd_addr, bus.o_wr_data});
  endfunction

  function automatic logic [BURST_W-1:0] rrData(input int c, input int k);
    return {16'(c), 16'(k), 16'hA5A5, 16'(c * 7 + k)};
  endfunction

  function automatic void pushAck(input int c, input logic we, input logic [ADDR_W-1:0] addr,
                                  input logic [BURST_W-1:0] data);
    ev_t ev;
    ev.is_ack = 1'b1;
    ev.ack    = NUM_CLIENTS'(1) << c;
    ev.wr     = we;
    ev.addr   = addr;
    ev.data   = data;
    ev.rvalid = '0;
    ev.err    = 1'b0;
    exp_q.push_back(ev);
  endfunction

  function automatic void pushDone(input logic [NUM_CLIENTS-1:0] rvalid, input logic err,
                                   input logic [BURST_W-1:0] data);
    ev_t ev;
    ev.is_ack = 1'b0;
    ev.ack    = '0;
    ev.wr     = 1'b0;
    ev.addr   = '0;
    ev.data   = data;
    ev.rvalid = rvalid;
    ev.err    = err;
    exp_q.push_back(ev);
  endfunction

  // Any strobe, ack, rvalid or err must match the next expected event in order.
  always @(negedge clk) begin
    if (rst_n && (bus.o_ack != '0 || bus.o_rvalid != '0 || bus.o_err || bus.o_wr_req || bus.o_rd_req)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected event",
                    256'({bus.o_ack, bus.o_rvalid, bus.o_err, bus.o_wr_req, bus.o_rd_req}), 256'(0));
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.is_ack) begin
          checkOutput("ack vector", 256'(bus.o_ack), 256'(mon_ev.ack));
          checkOutput("wr_req", 256'(bus.o_wr_req), 256'(mon_ev.wr));
          checkOutput("rd_req", 256'(bus.o_rd_req), 256'(!mon_ev.wr));
          if (mon_ev.wr) begin
            checkOutput("wr_addr", 256'(bus.o_wr_addr), 256'(mon_ev.addr));
            checkOutput("wr_data", 256'(bus.o_wr_data), 256'(mon_ev.data));
          end else begin
            checkOutput("rd_addr", 256'(bus.o_rd_addr), 256'(mon_ev.addr));
          end
        end else begin
          checkOutput("rvalid vector", 256'(bus.o_rvalid), 256'(mon_ev.rvalid));
          checkOutput("err", 256'(bus.o_err), 256'(mon_ev.err));
          checkOutput("ack during completion", 256'(bus.o_ack), 256'(0));
          if (mon_ev.rvalid != '0) begin
            checkOutput("rdata", 256'(bus.o_rdata), 256'(mon_ev.data));
          end
        end
      end
    end
  end

  task automatic waitAck(input int c, output int latency);
    latency = 0;
    for (int k = 1; k <= 400 && latency == 0; k++) begin
      @(negedge clk);
      if (bus.o_ack[c]) latency = k;
    end
    checkOutput($sformatf("ack arrives c%0d", c), 256'(latency != 0), 256'(1));
  endtask

  task automatic applyStimulus(input int c, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [BURST_W-1:0] data, output int latency);
    bus.i_we[c]    = we;
    bus.i_addr[c]  = addr;
    bus.i_wdata[c] = data;
    bus.i_req[c]   = 1'b1;
    pushAck(c, we, addr, data);
    waitAck(c, latency);
    bus.i_req[c]   = 1'b0;
  endtask

  task automatic clientRun(input int c, input int n, input logic [ADDR_W-1:0] base, output int acks);
    int latency;
    acks = 0;
    for (int k = 0; k < n; k++) begin
      bus.i_we[c]    = 1'b1;
      bus.i_addr[c]  = base + ADDR_W'(k);
      bus.i_wdata[c] = rrData(c, k);
      bus.i_req[c]   = 1'b1;
      waitAck(c, latency);
      if (latency != 0) acks++;
    end
    bus.i_req[c] = 1'b0;
  endtask

  task automatic countBusy(input bit spurious, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!bus.o_busy) break;
      n++;
      if (spurious && k == 2) begin
        bus.i_rd_data = {4{16'hDEAD}};
        bus.i_rd_rdy  = 1'b1;
      end else begin
        bus.i_rd_rdy  = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_rd_rdy = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (!bus.o_busy) break;
      @(negedge clk);
    end
    checkOutput(tag, 256'(bus.o_busy), 256'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_req     = '0;
    bus.i_we      = '0;
    bus.i_addr    = '0;
    bus.i_wdata   = '0;
    bus.i_rd_data = '0;
    bus.i_rd_rdy  = 1'b0;

    $display("[TB] reset state");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("outputs in reset", allOutputs(), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", allOutputs(), 256'(0));

    $display("[TB] single write from client 0");
    applyStimulus(0, 1'b1, 22'h000123, {16'd1, 16'd2, 16'd3, 16'd4}, lat);
    checkOutput("write ack latency", 256'(lat), 256'(1));
    countBusy(1'b0, busy_n);
    checkOutput("write busy cycles", 256'(busy_n), 256'(WR_REC + 1));

    $display("[TB] write from client 1 with spurious rd_rdy");
    applyStimulus(1, 1'b1, 22'h3FFFFF, {16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE}, lat);
    checkOutput("write2 ack latency", 256'(lat), 256'(1));
    countBusy(1'b1, busy_n);
    checkOutput("write2 busy cycles", 256'(busy_n), 256'(WR_REC + 1));
    checkOutput("rdata untouched by spurious rdy", 256'(bus.o_rdata), 256'(0));

    $display("[TB] round robin, both clients requesting");
    for (int k = 0; k < 4; k++) begin
      pushAck(0, 1'b1, 22'h100000 + ADDR_W'(k), rrData(0, k));
      pushAck(1, 1'b1, 22'h200000 + ADDR_W'(k), rrData(1, k));
    end
    fork
      clientRun(0, 4, 22'h100000, acks0);
      clientRun(1, 4, 22'h200000, acks1);
    join
    checkOutput("rr acks client 0", 256'(acks0), 256'(4));
    checkOutput("rr acks client 1", 256'(acks1), 256'(4));
    waitIdle("idle after round robin");

    $display("[TB] read from client 1");
    rd_exp = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    applyStimulus(1, 1'b0, 22'h2A0005, '0, lat);
    checkOutput("read ack latency", 256'(lat), 256'(1));
    pushDone(2'b10, 1'b0, rd_exp);
    repeat (7) @(negedge clk);
    bus.i_rd_data = rd_exp;
    bus.i_rd_rdy  = 1'b1;
    @(negedge clk);
    bus.i_rd_rdy  = 1'b0;
    checkOutput("read rvalid one cycle after rdy", 256'(bus.o_rvalid), 256'(2'b10));
    checkOutput("read rdata", 256'(bus.o_rdata), 256'(rd_exp));

    $display("[TB] read timeout from client 0");
    applyStimulus(0, 1'b0, 22'h00ABCD, '0, lat);
    pushDone(2'b00, 1'b1, '0);
    err_lat = 0;
    for (int k = 1; k <= 50 && err_lat == 0; k++) begin
      @(negedge clk);
      if (bus.o_err) err_lat = k;
    end
    checkOutput("timeout err latency", 256'(err_lat), 256'(RD_TO + 1));
    @(negedge clk);
    checkOutput("err single pulse", 256'(bus.o_err), 256'(0));
    checkOutput("rdata held across timeout", 256'(bus.o_rdata), 256'(rd_exp));
    applyStimulus(1, 1'b1, 22'h012345, rrData(5, 5), lat);
    checkOutput("grant after timeout latency", 256'(lat), 256'(1));
    waitIdle("idle after post-timeout write");

    $display("[TB] rd_rdy on the last timeout cycle");
    applyStimulus(0, 1'b0, 22'h155555, '0, lat);
    pushDone(2'b01, 1'b0, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
    repeat (RD_TO) @(negedge clk);
    bus.i_rd_data = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.i_rd_rdy  = 1'b1;
    @(negedge clk);
    bus.i_rd_rdy  = 1'b0;
    checkOutput("late rdy rvalid", 256'(bus.o_rvalid), 256'(2'b01));
    checkOutput("late rdy no err", 256'(bus.o_err), 256'(0));

    $display("[TB] reset in the middle of a read");
    applyStimulus(0, 1'b0, 22'h0F0F0F, '0, lat);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("outputs after mid-read reset", allOutputs(), 256'(0));
    rst_n = 1'b1;
    bus.i_rd_data = {4{16'hBEEF}};
    bus.i_rd_rdy  = 1'b1;
    @(negedge clk);
    bus.i_rd_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no rvalid after reset", 256'(bus.o_rvalid), 256'(0));
    checkOutput("idle after reset", 256'(bus.o_busy), 256'(0));

    $display("[TB] pointer restarts at client 0 after reset");
    pushAck(0, 1'b1, 22'h300000, rrData(0, 0));
    pushAck(1, 1'b1, 22'h380000, rrData(1, 0));
    fork
      clientRun(0, 1, 22'h300000, acks0);
      clientRun(1, 1, 22'h380000, acks1);
    join
    waitIdle("idle at end");

    checkOutput("scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
